// File: rtl/mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl
//
// Sequencer for a multi-cycle signed multiply/divide unit and owner of the
// architectural HI/LO registers. It latches the operands, clears the unit,
// runs it for a fixed number of cycles, captures the result into HI/LO and
// pulses done. Divide-by-zero (detected up front or reported by the unit
// while running) ends the operation with a one-cycle exception pulse
// instead. mthi/mtlo writes are accepted only while idle.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (0 = reset)
//   start_mult    request signed multiply rs_val * rt_val
//   start_div     request signed divide rs_val / rt_val
//   abort         cancel the operation in flight
//   write_hi/lo   mthi/mtlo: write rs_val into hi/lo
//   rs_val/rt_val operands from the register file
//   unit_hi/lo    results from the arithmetic unit
//   unit_divzero  divide-by-zero flag from the arithmetic unit
//   op_a/op_b     latched operands to the arithmetic unit
//   unit_ctrl     unit opcode: 00 idle, 01 multiply, 10 divide
//   unit_clr      active-high clear to the arithmetic unit
//   busy          operation in flight (LOAD, RUN, CAPT)
//   done          one-cycle completion pulse
//   div_zero_exc  one-cycle divide-by-zero exception pulse
//   hi/lo         architectural HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        abort,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  input  logic        unit_divzero,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  unit_ctrl,
  output logic        unit_clr,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE, EXC} state_t;

  localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [5:0] cnt;
  logic       is_div;
  logic       init_q;
  logic       abort_clr_q;
  logic       run_last;
  logic       accept_start;
  logic       any_start;

  // The counter runs 0..N-1 in RUN, so RUN lasts exactly N cycles.
  assign run_last = (cnt == (is_div ? DIV_LAST : MULT_LAST));

  // init_q holds off starts until the first edge after reset release, so the
  // unit sees its clear for a full cycle before any operation can begin.
  // An abort arriving in the same cycle as a start also wins over it.
  assign accept_start = !init_q && !abort;
  assign any_start    = start_mult || start_div;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. unit_clr also covers the cycle after
  // reset release (init_q) and the idle cycle that follows an abort
  // (abort_clr_q). Abort overrides every transition and masks the
  // completion/exception pulses of the cycle it arrives in.
  always_comb begin
    next_state   = state;
    busy         = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    unit_ctrl    = 2'b00;
    unit_clr     = init_q | abort_clr_q;
    case (state)
      IDLE: begin
        if (accept_start) begin
          if (start_mult) begin
            next_state = LOAD;
          end else if (start_div) begin
            next_state = (rt_val == 32'd0) ? EXC : LOAD;
          end
        end
      end
      LOAD: begin
        busy       = 1'b1;
        unit_clr   = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        unit_ctrl = is_div ? 2'b10 : 2'b01;
        if (is_div && unit_divzero) begin
          next_state = EXC;
        end else if (run_last) begin
          next_state = CAPT;
        end
      end
      CAPT: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      EXC: begin
        div_zero_exc = 1'b1;
        unit_clr     = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort && state != IDLE) begin
      next_state   = IDLE;
      done         = 1'b0;
      div_zero_exc = 1'b0;
    end
  end

  // Datapath: operand latch on entry to LOAD (held through CAPT), RUN
  // counter, result capture at the end of CAPT, and mthi/mtlo writes that
  // only land when idle and no start is presented in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= 6'd0;
      is_div      <= 1'b0;
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      init_q      <= 1'b1;
      abort_clr_q <= 1'b0;
    end else begin
      init_q      <= 1'b0;
      abort_clr_q <= abort && (state != IDLE);
      if (state == IDLE && next_state == LOAD) begin
        op_a   <= rs_val;
        op_b   <= rt_val;
        is_div <= !start_mult;
      end
      if (state == LOAD) begin
        cnt <= 6'd0;
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
      end
      if (state == CAPT && !abort) begin
        hi <= unit_hi;
        lo <= unit_lo;
      end else if (state == IDLE && !any_start) begin
        if (write_hi) hi <= rs_val;
        if (write_lo) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_div_ctrl
//
// Self-checking bench for mult_div_ctrl. A behavioural arithmetic unit
// answers the controller; every expected completion or exception is queued
// when its stimulus is driven and compared (kind, HI/LO, cycle, busy length)
// when the controller pulses done or div_zero_exc.
// ---------------------------------------------------------------------------
module tb_mult_div_ctrl;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic        abort = 1'b0;
  logic        write_hi = 1'b0;
  logic        write_lo = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [31:0] unit_hi = 32'd0;
  logic [31:0] unit_lo = 32'd0;
  logic        unit_divzero;
  logic        force_dz = 1'b0;
  logic [31:0] op_a, op_b, hi, lo;
  logic [1:0]  unit_ctrl;
  logic        unit_clr, busy, done, div_zero_exc;

  typedef struct {
    bit          is_exc;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  mult_div_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .abort(abort), .write_hi(write_hi), .write_lo(write_lo),
    .rs_val(rs_val), .rt_val(rt_val), .unit_hi(unit_hi), .unit_lo(unit_lo),
    .unit_divzero(unit_divzero), .op_a(op_a), .op_b(op_b),
    .unit_ctrl(unit_ctrl), .unit_clr(unit_clr), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .hi(hi), .lo(lo)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural arithmetic unit: signed multiply into {hi,lo}, signed divide
  // with quotient in lo and remainder in hi; cleared by unit_clr.
  assign unit_divzero = force_dz;

  always @(posedge clk) begin
    if (unit_clr) begin
      unit_hi <= 32'd0;
      unit_lo <= 32'd0;
    end else if (unit_ctrl == 2'b01) begin
      {unit_hi, unit_lo} <= 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
    end else if (unit_ctrl == 2'b10 && op_b != 32'd0) begin
      unit_lo <= 32'($signed(op_a) / $signed(op_b));
      unit_hi <= 32'($signed(op_a) % $signed(op_b));
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one start request (called just after a falling edge) and queue its
  // expected outcome. kind: 0 = done, 1 = exception, 2 = nothing expected.
  task automatic applyStimulus(input bit m, input bit d, input logic [31:0] a,
                               input logic [31:0] b, input int kind,
                               input logic [31:0] ehi, input logic [31:0] elo,
                               input int lat, input int ebusy);
    exp_t e;
    start_mult = m;
    start_div  = d;
    rs_val     = a;
    rt_val     = b;
    if (kind != 2) begin
      e.is_exc = (kind == 1);
      e.hi     = ehi;
      e.lo     = elo;
      e.cyc    = cyc + lat;
      e.busy   = ebusy;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  task automatic writeRegs(input bit wh, input bit wl, input logic [31:0] v);
    write_hi = wh;
    write_lo = wl;
    rs_val   = v;
    @(negedge clk);
    write_hi = 1'b0;
    write_lo = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compare every done/exception pulse with the oldest
  // queued expectation; also measure how long busy was high before it.
  always @(negedge clk) begin
    exp_t e;
    if (done || div_zero_exc) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", 64'({done, div_zero_exc}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("evt_exc", 64'(div_zero_exc), 64'(e.is_exc));
        checkOutput("evt_done", 64'(done), 64'(!e.is_exc));
        checkOutput("evt_hilo", {hi, lo}, {e.hi, e.lo});
        checkOutput("evt_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("evt_busy_len", 64'(busy_cnt), 64'(e.busy));
        if (e.is_exc) checkOutput("exc_clr", 64'(unit_clr), 64'd1);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Main sequence.
  initial begin
    #12;
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_ops", {op_a, op_b}, 64'd0);
    checkOutput("reset_flags", 64'({busy, done, div_zero_exc, unit_ctrl, unit_clr}), 64'b000001);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("clr_before_edge", 64'(unit_clr), 64'd1);
    @(negedge clk);
    checkOutput("clr_after_edge", 64'(unit_clr), 64'd0);

    $display("[TB] mthi/mtlo together");
    writeRegs(1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("write_both", {hi, lo}, {32'hDEADBEEF, 32'hDEADBEEF});

    $display("[TB] multiply 7 * -3");
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, MULT_N + 3, MULT_N + 2);
    waitIdle(100);

    $display("[TB] divide -7 / 2");
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N + 3, DIV_N + 2);
    waitIdle(100);

    $display("[TB] preload and divide by zero");
    writeRegs(1'b1, 1'b0, 32'h11111111);
    writeRegs(1'b0, 1'b1, 32'h22222222);
    checkOutput("preload", {hi, lo}, {32'h11111111, 32'h22222222});
    applyStimulus(1'b0, 1'b1, 32'd9, 32'd0, 1, 32'h11111111, 32'h22222222, 1, 0);
    waitIdle(10);

    $display("[TB] unit divide-by-zero during run");
    applyStimulus(1'b0, 1'b1, 32'd50, 32'd5, 1, 32'h11111111, 32'h22222222, 7, 6);
    repeat (5) @(negedge clk);
    force_dz = 1'b1;
    @(negedge clk);
    force_dz = 1'b0;
    waitIdle(10);

    $display("[TB] abort in run cycle 10, then immediate restart");
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, 2, 32'd0, 32'd0, 0, 0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_state", 64'({busy, unit_ctrl, unit_clr}), 64'b0001);
    checkOutput("abort_hilo", {hi, lo}, {32'h11111111, 32'h22222222});
    applyStimulus(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 0, 32'd2, 32'hFFFFFFF2, DIV_N + 3, DIV_N + 2);
    waitIdle(100);

    $display("[TB] abort clear lasts one cycle");
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd2, 2, 32'd0, 32'd0, 0, 0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort2_clr_on", 64'(unit_clr), 64'd1);
    @(negedge clk);
    checkOutput("abort2_clr_off", 64'({busy, unit_clr}), 64'd0);
    checkOutput("abort2_hilo", {hi, lo}, {32'd2, 32'hFFFFFFF2});

    $display("[TB] writes and starts while busy are ignored");
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 0, 32'd0, 32'd12, MULT_N + 3, MULT_N + 2);
    repeat (3) @(negedge clk);
    rs_val    = 32'hDEADBEEF;
    rt_val    = 32'd0;
    write_hi  = 1'b1;
    write_lo  = 1'b1;
    start_div = 1'b1;
    @(negedge clk);
    write_hi  = 1'b0;
    write_lo  = 1'b0;
    start_div = 1'b0;
    checkOutput("busy_write", {hi, lo}, {32'd2, 32'hFFFFFFF2});
    checkOutput("ops_stable", {op_a, op_b}, {32'd3, 32'd4});
    waitIdle(100);
    repeat (40) @(negedge clk);

    $display("[TB] both starts: multiply wins");
    applyStimulus(1'b1, 1'b1, 32'hFFFFFFFB, 32'd6, 0, 32'hFFFFFFFF, 32'hFFFFFFE2, MULT_N + 3, MULT_N + 2);
    waitIdle(100);

    $display("[TB] reset mid-divide");
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd3, 2, 32'd0, 32'd0, 0, 0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_hilo", {hi, lo}, 64'd0);
    checkOutput("midreset_ops", {op_a, op_b}, 64'd0);
    checkOutput("midreset_flags", 64'({busy, done, div_zero_exc, unit_ctrl, unit_clr}), 64'b000001);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("release_clr_on", 64'(unit_clr), 64'd1);
    @(negedge clk);
    checkOutput("release_clr_off", 64'(unit_clr), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd7, 0, 32'd0, 32'd42, MULT_N + 3, MULT_N + 2);
    waitIdle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 32, SHALL set the number of RUN cycles for a multiply.
REQ-002 Parameter DIV_CYCLES, default 33, SHALL set the number of RUN cycles for a divide.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 start_mult  input  1  SHALL request a signed multiply of rs_val by rt_val.
REQ-006 start_div  input  1  SHALL request a signed divide of rs_val by rt_val.
REQ-007 abort  input  1  SHALL cancel any operation in progress.
REQ-008 write_hi / write_lo  input  1 each  SHALL request mthi/mtlo, writing rs_val into hi/lo.
REQ-009 rs_val, rt_val  input  32 each  SHALL be the operands from the register file.
REQ-010 unit_hi, unit_lo  input  32 each  SHALL be the results returned by the arithmetic unit.
REQ-011 unit_divzero  input  1  SHALL be the divide-by-zero flag from the arithmetic unit.
REQ-012 op_a, op_b  output  32 each  SHALL be the latched operands driven to the arithmetic unit.
REQ-013 unit_ctrl  output  2  SHALL be the unit opcode: 00 = idle, 01 = multiply, 10 = divide.
REQ-014 unit_clr  output  1  SHALL be the active-high clear to the arithmetic unit.
REQ-015 busy, done, div_zero_exc  output  1 each  SHALL flag operation in flight, a 1-cycle completion pulse, and a 1-cycle divide-by-zero exception pulse.
REQ-016 hi, lo  output  32 each  SHALL be the architectural HI/LO registers.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, CAPT, DONE and EXC.
REQ-018 In IDLE, start_mult SHALL take priority over start_div when both are asserted; either start SHALL move the FSM to LOAD and latch rs_val/rt_val into op_a/op_b.
REQ-019 In IDLE, start_div with rt_val==0 SHALL go to EXC instead of LOAD.
REQ-020 LOAD SHALL last 1 cycle with unit_clr=1 and unit_ctrl=00, then go to RUN.
REQ-021 RUN SHALL hold unit_ctrl at 01 (mult) or 10 (div) for exactly MULT_CYCLES or DIV_CYCLES cycles, counted by a 6-bit counter cleared in LOAD.
REQ-022 CAPT SHALL last 1 cycle with unit_ctrl=00, load hi<=unit_hi and lo<=unit_lo at its end, then go to DONE.
REQ-023 DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-024 busy SHALL be 1 in LOAD, RUN and CAPT, and 0 otherwise.
REQ-025 Latency: for a start sampled at edge k, done SHALL be high in cycle k+N+3, where N is the RUN length.
REQ-026 unit_divzero=1 during a divide RUN SHALL go to EXC at the next edge.
REQ-027 EXC SHALL assert div_zero_exc for 1 cycle, assert unit_clr, leave hi/lo unchanged, and then go to IDLE.
REQ-028 abort in any non-IDLE state SHALL go to IDLE at the next edge, assert unit_clr for that cycle, suppress done/div_zero_exc, and leave hi/lo unchanged.
REQ-029 abort SHALL take priority over every other transition.
REQ-030 Starts received while busy SHALL be ignored, not queued.
REQ-031 write_hi/write_lo SHALL take effect only in IDLE with no start asserted in the same cycle; otherwise they SHALL be ignored.
REQ-032 write_hi and write_lo asserted together SHALL write both registers.
REQ-033 op_a/op_b SHALL stay constant from LOAD through CAPT.

Reset
REQ-034 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, hi=lo=op_a=op_b=0, unit_ctrl=00, busy=done=div_zero_exc=0, and unit_clr=1.
REQ-035 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-036 After reset release, unit_clr SHALL deassert at the first rising edge, and the block SHALL accept a start at the second rising edge.

Verification
REQ-037 start_mult with rs=7, rt=0xFFFFFFFD (-3) and the unit model -> busy for 34 cycles, done at k+35, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-038 start_div with rs=0xFFFFFFF9 (-7), rt=2 -> done at k+36, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 start_div with rt=0, and hi/lo preloaded to 0x11111111/0x22222222 -> div_zero_exc pulses once, no LOAD, hi/lo unchanged.
REQ-040 abort in RUN cycle 10 of a multiply -> IDLE next edge, unit_clr=1 for 1 cycle, no done, hi/lo unchanged; a new start is accepted immediately afterwards.
REQ-041 reset=0 mid-divide between clock edges -> all outputs at reset values before the next edge, with no done pulse.
REQ-042 write_hi=write_lo=1 with rs=0xDEADBEEF in IDLE -> hi=lo=0xDEADBEEF; the same request while busy -> no change.
